register_map_table_ifc: RTL and testbench
=========================================

// Module: register_map_table_ifc
// PURPOSE
//  Register rename map table (RAT) plus physical-register free list for the MIPS core rename stage.
//  Sits between decode and issue.
//  - Translates architectural rs/rt/rw numbers to physical register numbers.
//  - Allocates a fresh physical register for each renamed destination.
//  - Returns physical registers to the free list when the commit stage frees them.
// PARAMETERS
//  ARCH_REGS  32  number of architectural registers (address width AW = $clog2(ARCH_REGS) = 5)
//  PHYS_REGS  64  number of physical registers (tag width PW = $clog2(PHYS_REGS) = 6)
// PORTS
//  clk            in   1          core clock; all state updates on posedge
//  rst_n          in   1          synchronous reset, active-low
//  uses_rs        in   1          instruction reads rs
//  rs_addr        in   AW         architectural rs
//  rs_phys        out  PW         physical rs; 0 when !uses_rs
//  uses_rt        in   1          instruction reads rt
//  rt_addr        in   AW         architectural rt
//  rt_phys        out  PW         physical rt; 0 when !uses_rt
//  uses_rw        in   1          instruction writes rw
//  rw_addr        in   AW         architectural destination
//  rename_valid   in   1          rename request this cycle
//  rename_ready   out  1          free list non-empty (registered state)
//  rw_phys        out  PW         newly allocated physical destination
//  old_phys       out  PW         previous mapping of rw_addr, to be freed at commit
//  free_valid     in   1          release one physical register
//  free_phys      in   PW         physical register to release
//  free_list_out  out  PHYS_REGS  bit i = 1 means physical register i is free
//  free_count     out  PW+1       popcount of free_list_out
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge):
//    - map[i] = i for all i.
//    - Free bits 0..31 = 0; free bits 32..63 = 1.
//    - Resulting outputs: free_count = 32, rename_ready = 1.
//  - Source lookups are combinational from the current map (zero latency).
//    - A same-cycle rename of rw_addr == rs_addr/rt_addr does not affect rs_phys/rt_phys;
//      the old mapping is returned.
//  - fire = rename_valid & uses_rw & rename_ready.
//    - Allocation picks the lowest-index free bit (priority encoder).
//  - rw_phys (combinational):
//    - fire: the allocated tag.
//    - uses_rw & !fire: map[rw_addr].
//    - otherwise: 0.
//  - old_phys = map[rw_addr] (pre-update) whenever uses_rw; otherwise 0.
//  - On posedge with fire: map[rw_addr] <= alloc and free bit[alloc] <= 0. Rename is 1-cycle latency.
//  - On posedge with free_valid: free bit[free_phys] <= 1.
//    - Freeing an already-free register is a no-op.
//    - The freed register becomes allocatable the next cycle; there is no same-cycle bypass.
//  - Simultaneous fire and free: both take effect; the indices can never collide.
//  - Empty free list:
//    - rename_ready = 0.
//    - rename_valid is ignored: no state change, rw_phys = map[rw_addr].
//  - free_count is always consistent with free_list_out. It cannot exceed PHYS_REGS - ARCH_REGS
//    unless a double-free occurs.
//  - Reset has priority over fire and free in the same cycle.
// CONFIGURATION
//  MAP_TABLE_ZERO_PIN_EN
//  - Defined:
//    - Architectural r0 is permanently mapped to physical 0.
//    - A rename with rw_addr == 0 does not fire: no allocation, rw_phys = 0, old_phys = 0.
//    - free_valid with free_phys == 0 is ignored.
//  - Undefined: r0 is renamed like any other register.
// TESTING
//  1. Reset, then a lookup with rs_addr=5, rt_addr=31 -> rs_phys=5, rt_phys=31,
//     free_count=32, free_list_out=64'hFFFF_FFFF_0000_0000.
//  2. Rename rw_addr=3 -> rw_phys=32, old_phys=3. Next cycle: lookup of r3 -> 33's predecessor 32;
//     second rename of rw_addr=3 -> rw_phys=33, old_phys=32.
//  3. Same cycle: rs_addr=rw_addr=7 with a rename -> rs_phys=7. Next cycle: rs_phys=32.
//  4. 32 back-to-back renames -> free_count=0, rename_ready=0.
//     33rd rename: no change.
//     free_valid with free_phys=4 -> next cycle rename_ready=1; following rename gets rw_phys=4.
//  5. Simultaneous rename and free_phys=0 -> both applied, free_count unchanged.
//     Double-free of the same tag -> no further change.
//  6. With MAP_TABLE_ZERO_PIN_EN: rename rw_addr=0 -> rw_phys=0, free_count unchanged;
//     freeing phys 0 is ignored.

Source files
------------

// File: rtl/register_map_table_ifc_if.sv
// Rename-stage bus between decode/issue and the register map table.
// master: decode/issue side (drives lookups, rename requests, commit frees).
// slave : map table (returns physical tags, free-list state).
// Ports carried: uses_rs/rs_addr/rs_phys, uses_rt/rt_addr/rt_phys,
//   uses_rw/rw_addr/rename_valid/rename_ready/rw_phys/old_phys,
//   free_valid/free_phys, free_list_out/free_count.
interface register_map_table_ifc_if #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PHYS_REGS = 64
);
  localparam int unsigned AW = $clog2(ARCH_REGS);
  localparam int unsigned PW = $clog2(PHYS_REGS);

  logic                 uses_rs;
  logic [AW-1:0]        rs_addr;
  logic [PW-1:0]        rs_phys;
  logic                 uses_rt;
  logic [AW-1:0]        rt_addr;
  logic [PW-1:0]        rt_phys;
  logic                 uses_rw;
  logic [AW-1:0]        rw_addr;
  logic                 rename_valid;
  logic                 rename_ready;
  logic [PW-1:0]        rw_phys;
  logic [PW-1:0]        old_phys;
  logic                 free_valid;
  logic [PW-1:0]        free_phys;
  logic [PHYS_REGS-1:0] free_list_out;
  logic [PW:0]          free_count;

  modport master (
    output uses_rs, rs_addr, uses_rt, rt_addr, uses_rw, rw_addr,
           rename_valid, free_valid, free_phys,
    input  rs_phys, rt_phys, rename_ready, rw_phys, old_phys,
           free_list_out, free_count
  );

  modport slave (
    input  uses_rs, rs_addr, uses_rt, rt_addr, uses_rw, rw_addr,
           rename_valid, free_valid, free_phys,
    output rs_phys, rt_phys, rename_ready, rw_phys, old_phys,
           free_list_out, free_count
  );
endinterface

// File: rtl/register_map_table_ifc.sv
// Register alias table plus physical-register free list for the rename stage.
// Ports: clk, rst_n (synchronous, active-low), bus (register_map_table_ifc_if.slave).
//   Source lookups and rw_phys/old_phys are combinational from the current map;
//   rename_ready, free_list_out and free_count come straight from registers.
// Option: define MAP_TABLE_ZERO_PIN_EN to pin architectural r0 to physical 0
//   (renames of r0 never fire, frees of physical 0 are dropped).
module register_map_table_ifc #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PHYS_REGS = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  register_map_table_ifc_if.slave  bus
);
  localparam int unsigned PW = $clog2(PHYS_REGS);
  localparam int unsigned CW = PW + 1;
  localparam logic [PHYS_REGS-1:0] RST_FREE =
    {{(PHYS_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};

  logic [PW-1:0]        map_q [ARCH_REGS];
  logic [PHYS_REGS-1:0] free_q;
  logic [PHYS_REGS-1:0] free_d;
  logic [CW-1:0]        count_q;
  logic [CW-1:0]        count_d;
  logic                 ready_q;
  logic [PW-1:0]        alloc;
  logic                 fire;
  logic                 free_en;

  // Lowest-index free register; scanning downward lets the last hit win.
  always_comb begin
    alloc = '0;
    for (int i = PHYS_REGS - 1; i >= 0; i--) begin
      if (free_q[i]) alloc = PW'(i);
    end
  end

`ifdef MAP_TABLE_ZERO_PIN_EN
  assign fire    = bus.rename_valid & bus.uses_rw & ready_q & (bus.rw_addr != '0);
  assign free_en = bus.free_valid & (bus.free_phys != '0);
`else
  assign fire    = bus.rename_valid & bus.uses_rw & ready_q;
  assign free_en = bus.free_valid;
`endif

  // Lookups see the pre-update map, so a same-cycle rename never bypasses.
  assign bus.rs_phys  = bus.uses_rs ? map_q[bus.rs_addr] : '0;
  assign bus.rt_phys  = bus.uses_rt ? map_q[bus.rt_addr] : '0;
  assign bus.old_phys = bus.uses_rw ? map_q[bus.rw_addr] : '0;
  assign bus.rw_phys  = fire        ? alloc
                      : bus.uses_rw ? map_q[bus.rw_addr] : '0;

  assign bus.rename_ready  = ready_q;
  assign bus.free_list_out = free_q;
  assign bus.free_count    = count_q;

  // Next free list and its popcount; ready/count are registered from it.
  always_comb begin
    free_d  = free_q;
    count_d = '0;
    if (fire)    free_d[alloc]         = 1'b0;
    if (free_en) free_d[bus.free_phys] = 1'b1;
    for (int i = 0; i < PHYS_REGS; i++) begin
      count_d = count_d + CW'(free_d[i]);
    end
  end

  // State update; reset overrides any concurrent rename or free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        map_q[i] <= PW'(i);
      end
      free_q  <= RST_FREE;
      count_q <= CW'(PHYS_REGS - ARCH_REGS);
      ready_q <= 1'b1;
    end else begin
      if (fire) map_q[bus.rw_addr] <= alloc;
      free_q  <= free_d;
      count_q <= count_d;
      ready_q <= |free_d;
    end
  end
endmodule

// File: tb/tb_register_map_table_ifc.sv
// Randomized scoreboard bench for register_map_table_ifc: a behavioural model
// predicts each cycle's outputs, a monitor compares them on the falling edge.
module tb_register_map_table_ifc;
  logic clk;
  logic rst_n;

  register_map_table_ifc_if bus ();

  register_map_table_ifc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [5:0]  rs;
    logic [5:0]  rt;
    logic [5:0]  rw;
    logic [5:0]  old;
    logic        ready;
    logic [6:0]  cnt;
    logic [63:0] list;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   stim_done   = 0;

  // Reference model: architectural map and set of free physical registers.
  int map_m [32];
  bit free_m [64];

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) map_m[i] = i;
    for (int i = 0; i < 64; i++) free_m[i] = (i >= 32);
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 64; i++) n += free_m[i];
    return n;
  endfunction

  function automatic int model_lowest_free();
    for (int i = 0; i < 64; i++) if (free_m[i]) return i;
    return -1;
  endfunction

  function automatic void chk(string nm, int id, logic [63:0] act, logic [63:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s vec=%0d: got %h expected %h", nm, id, act, exp);
    end
  endfunction

  // One cycle of stimulus: drive, predict, push, then advance the model.
  task automatic apply(input bit rst, input bit urs, input int rs, input bit urt,
                       input int rt, input bit urw, input int rw, input bit rv,
                       input bit fv, input int fp);
    exp_t e;
    bit   fire;
    int   alloc;
    bit   fv_eff;
    @(posedge clk);
    #1;
    alloc = model_lowest_free();
    fire  = rv && urw && (alloc >= 0);
`ifdef MAP_TABLE_ZERO_PIN_EN
    if (rw == 0) fire = 0;
`endif
    // A tag being allocated cannot simultaneously be released by commit.
    if (fire && fv && fp == alloc) fv = 0;
    rst_n            = !rst;
    bus.uses_rs      = urs;
    bus.rs_addr      = 5'(rs);
    bus.uses_rt      = urt;
    bus.rt_addr      = 5'(rt);
    bus.uses_rw      = urw;
    bus.rw_addr      = 5'(rw);
    bus.rename_valid = rv;
    bus.free_valid   = fv;
    bus.free_phys    = 6'(fp);

    e.id    = vectors;
    e.rs    = urs ? 6'(map_m[rs]) : 6'd0;
    e.rt    = urt ? 6'(map_m[rt]) : 6'd0;
    e.old   = urw ? 6'(map_m[rw]) : 6'd0;
    e.rw    = fire ? 6'(alloc) : e.old;
    e.cnt   = 7'(model_count());
    e.ready = (e.cnt != 0);
    for (int i = 0; i < 64; i++) e.list[i] = free_m[i];
    exp_q.push_back(e);
    vectors++;

    fv_eff = fv;
`ifdef MAP_TABLE_ZERO_PIN_EN
    if (fp == 0) fv_eff = 0;
`endif
    if (rst) model_reset();
    else begin
      if (fire) begin
        map_m[rw]     = alloc;
        free_m[alloc] = 0;
      end
      if (fv_eff) free_m[fp] = 1;
    end
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rename(input int rw);
    apply(0, 0, 0, 0, 0, 1, rw, 1, 0, 0);
  endtask

  task automatic release_tag(input int fp);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, fp);
  endtask

  // Monitor: outputs are stable on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rs_phys",       e.id, 64'(bus.rs_phys),       64'(e.rs));
        chk("rt_phys",       e.id, 64'(bus.rt_phys),       64'(e.rt));
        chk("rw_phys",       e.id, 64'(bus.rw_phys),       64'(e.rw));
        chk("old_phys",      e.id, 64'(bus.old_phys),      64'(e.old));
        chk("rename_ready",  e.id, 64'(bus.rename_ready),  64'(e.ready));
        chk("free_count",    e.id, 64'(bus.free_count),    64'(e.cnt));
        chk("free_list_out", e.id, bus.free_list_out,      e.list);
      end
    end
  end

  initial begin
    rst_n            = 1'b0;
    bus.uses_rs      = 1'b0;
    bus.rs_addr      = '0;
    bus.uses_rt      = 1'b0;
    bus.rt_addr      = '0;
    bus.uses_rw      = 1'b0;
    bus.rw_addr      = '0;
    bus.rename_valid = 1'b0;
    bus.free_valid   = 1'b0;
    bus.free_phys    = '0;
    model_reset();
    @(posedge clk);

    // Reset state and plain lookups.
    apply(0, 1, 5, 1, 31, 0, 0, 0, 0, 0);
    // Back-to-back renames of r3 with a lookup of r3 on the second.
    rename(3);
    apply(0, 1, 3, 0, 0, 1, 3, 1, 0, 0);
    idle();
    // Same-cycle rename does not bypass into the source lookup.
    do_reset();
    apply(0, 1, 7, 1, 7, 1, 7, 1, 0, 0);
    apply(0, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    // Drain the free list, overflow, then recycle tag 4.
    do_reset();
    for (int i = 0; i < 32; i++) rename(i);
    rename(9);
    release_tag(4);
    rename(10);
    idle();
    // Simultaneous rename and free of tag 0, then double-frees.
    do_reset();
    apply(0, 0, 0, 0, 0, 1, 2, 1, 1, 0);
    release_tag(0);
    release_tag(0);
    release_tag(40);
    // r0 rename and a rename that may pick up tag 0.
    rename(0);
    rename(1);
    do_reset();
    rename(0);
    release_tag(0);
    idle();

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 3000; n++) begin
      apply($urandom_range(0, 199) == 0,
            1'($urandom), int'($urandom_range(0, 31)),
            1'($urandom), int'($urandom_range(0, 31)),
            $urandom_range(0, 9) < 8, int'($urandom_range(0, 31)),
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 4, int'($urandom_range(0, 63)));
    end
    idle();
    stim_done = 1;

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
